// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port of the UART boot loader.
//   imem_we_o    : one-cycle write strobe
//   imem_addr_o  : word address of the current write
//   imem_wdata_o : 32-bit write data
// master = the loader that drives the port, slave = the memory that receives it.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;

    modport master (
        output imem_we_o,
        output imem_addr_o,
        output imem_wdata_o
    );

    modport slave (
        input imem_we_o,
        input imem_addr_o,
        input imem_wdata_o
    );
endinterface

// File: rtl/uart_imem_loader.sv
// UART instruction-memory boot loader.
// Receives 8N1 bytes on rx_i and packs them little-endian into 32-bit words.
// Each word is written to instruction memory at consecutive addresses. The
// word END_WORD is not written: it releases the core from reset and locks
// the loader until the next reset.
//
// Ports:
//   wb_clk_i    : clock, all state on the rising edge
//   wb_rst_ni   : asynchronous active-low reset
//   rx_i        : UART receive line, idle high, asynchronous to wb_clk_i
//   imem        : instruction-memory write port (we / addr / wdata)
//   core_rst_no : active-low core reset, released when the load completes
//   done_o      : load complete, sticky
//   frame_err_o : stop-bit error seen, sticky
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | half a bit period in, confirm the start bit is still low
// DATA   | sample 8 data bits, one per bit period, LSB first
// STOP   | sample the stop bit; high = byte valid, low = frame error
// LOCKED | terminator seen, rx ignored until reset
module uart_imem_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          ADDR_W       = 12,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    rx_i,
    uart_imem_loader_if.master      imem,
    output logic                    core_rst_no,
    output logic                    done_o,
    output logic                    frame_err_o
);

    // Holds CLKS_PER_BIT-1 for every legal CLKS_PER_BIT, including powers of two.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOCKED
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             byte_valid;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_meta           <= 1'b1;
            rx_sync           <= 1'b1;
            state             <= IDLE;
            cnt               <= '0;
            bit_cnt           <= '0;
            shift_reg         <= '0;
            byte_valid        <= 1'b0;
            byte_idx          <= '0;
            word_buf          <= '0;
            imem.imem_we_o    <= 1'b0;
            imem.imem_addr_o  <= '0;
            imem.imem_wdata_o <= '0;
            core_rst_no       <= 1'b0;
            done_o            <= 1'b0;
            frame_err_o       <= 1'b0;
        end else begin
            rx_meta        <= rx_i;
            rx_sync        <= rx_meta;
            byte_valid     <= 1'b0;
            imem.imem_we_o <= 1'b0;

            if (imem.imem_we_o) begin
                imem.imem_addr_o <= imem.imem_addr_o + 1'b1;
            end

            // Bit timer is a down-counter: each phase loads its period minus
            // one and acts when it reaches zero.
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state   <= START;
                        cnt     <= HALF_LOAD;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_sync) begin
                        state <= DATA;
                        cnt   <= FULL_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        cnt       <= FULL_LOAD;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                end
                default: state <= IDLE;
            endcase

            // shift_reg is stable here: DATA cannot be re-entered within one
            // cycle of leaving STOP. The LOCKED assignment overrides any
            // start-bit detection made by the case above in the same cycle.
            if (byte_valid) begin
                if (byte_idx == 2'd3) begin
                    byte_idx <= '0;
                    if ({shift_reg, word_buf} != END_WORD) begin
                        imem.imem_we_o    <= 1'b1;
                        imem.imem_wdata_o <= {shift_reg, word_buf};
                    end else begin
                        done_o      <= 1'b1;
                        core_rst_no <= 1'b1;
                        state       <= LOCKED;
                    end
                end else begin
                    case (byte_idx)
                        2'd0:    word_buf[7:0]   <= shift_reg;
                        2'd1:    word_buf[15:8]  <= shift_reg;
                        default: word_buf[23:16] <= shift_reg;
                    endcase
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

endmodule
